// File: rtl/cpu_run_ctrl_if.sv
// ============================================================================
// cpu_run_ctrl_if : board buttons / breakpoint inputs and CPU control outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface cpu_run_ctrl_if;
  logic        btn1;
  logic        btn2;
  logic [31:0] pc;
  logic [31:0] break_addr;
  logic        cpu_reset_n;
  logic        cpu_clk_en;
  logic        step_mode;
  logic [2:0]  state_dbg;

  // master = run controller, slave = board/CPU side
  modport master (
    input  btn1, btn2, pc, break_addr,
    output cpu_reset_n, cpu_clk_en, step_mode, state_dbg
  );

  modport slave (
    output btn1, btn2, pc, break_addr,
    input  cpu_reset_n, cpu_clk_en, step_mode, state_dbg
  );
endinterface

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// cpu_run_ctrl : button debounce, timed CPU reset hold, free-run/single-step
// Optional breakpoint halt: define RUN_CTRL_BREAKPOINT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 65535,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int CNT_W             = 16
) (
  input  wire                  clk,
  input  wire                  reset,
  cpu_run_ctrl_if.master       bus
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    HOLD_RST   = 3'd1,
    RUN        = 3'd2,
    STEP_IDLE  = 3'd3,
    STEP_PULSE = 3'd4
  } state_e;

  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {bus.btn2, bus.btn1};

  // Per button: 2-flop synchronizer, stability counter, falling-edge pulse
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_prev_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        db_q      <= 1'b1;
        db_prev_q <= 1'b1;
        press_q   <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= btn_raw[gi];
        sync2_q   <= sync1_q;
        db_prev_q <= db_q;
        press_q   <= db_prev_q & ~db_q;
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[gi] = press_q;
  end

  logic press1;
  logic press2;
  logic bp_hit;

  assign press1 = press[0];
  assign press2 = press[1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             cpu_reset_n_q, cpu_reset_n_d;
  logic             cpu_clk_en_q, cpu_clk_en_d;
  logic             step_mode_q, step_mode_d;

`ifdef RUN_CTRL_BREAKPOINT_EN
  assign bp_hit = cpu_clk_en_q && (bus.pc == bus.break_addr);
`else
  logic unused_bp_ok;
  assign unused_bp_ok = ^{bus.pc, bus.break_addr};
  assign bp_hit       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= INIT;
      hold_q        <= '0;
      cpu_reset_n_q <= 1'b0;
      cpu_clk_en_q  <= 1'b0;
      step_mode_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      cpu_clk_en_q  <= cpu_clk_en_d;
      step_mode_q   <= step_mode_d;
    end
  end

  // press1 outranks press2 and the breakpoint in every state
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      INIT: begin
        state_d = HOLD_RST;
        hold_d  = '0;
      end
      HOLD_RST: begin
        if (press1) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (press1) begin
          state_d = HOLD_RST;
          hold_d  = '0;
        end else if (press2 || bp_hit) begin
          state_d = STEP_IDLE;
        end
      end
      STEP_IDLE: begin
        if (press1) begin
          state_d = HOLD_RST;
          hold_d  = '0;
        end else if (press2) begin
          state_d = STEP_PULSE;
        end
      end
      STEP_PULSE: begin
        if (press1) begin
          state_d = HOLD_RST;
          hold_d  = '0;
        end else begin
          state_d = STEP_IDLE;
        end
      end
      default: begin
        state_d = INIT;
        hold_d  = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q
    cpu_reset_n_d = (state_d == RUN) || (state_d == STEP_IDLE) || (state_d == STEP_PULSE);
    cpu_clk_en_d  = (state_d == RUN) || (state_d == STEP_PULSE);
    step_mode_d   = (state_d == STEP_IDLE) || (state_d == STEP_PULSE);
  end

  assign bus.cpu_reset_n = cpu_reset_n_q;
  assign bus.cpu_clk_en  = cpu_clk_en_q;
  assign bus.step_mode   = step_mode_q;
  assign bus.state_dbg   = state_q;

endmodule

`default_nettype wire
